// File: rtl/load_store_unit_pkg.sv
// RV32I load/store constants, FSM state type and access-size decode.
package Rv32iPkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} LsuStateT;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} AccSizeT;

  // Unlisted funct3 encodings fall back to word accesses.
  function automatic AccSizeT acc_size(input logic [2:0] f3, input logic is_load);
    AccSizeT sz;
    sz = SZ_WORD;
    if (is_load) begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response and memory-bus signals of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   ReqValid;
  logic                   ReqReady;
  logic [DATA_WIDTH-1:0]  AluOut;
  logic [DATA_WIDTH-1:0]  StoreData;
  logic [INSTR_WIDTH-1:0] Instr;
  logic                   RespValid;
  logic                   RespReady;
  logic [DATA_WIDTH-1:0]  LoadData;
  logic                   Misaligned;
  logic                   MemReq;
  logic                   MemWe;
  logic [DATA_WIDTH-1:0]  MemAddr;
  logic [DATA_WIDTH-1:0]  MemWdata;
  logic [3:0]             MemBe;
  logic                   MemGnt;
  logic                   MemRvalid;
  logic [DATA_WIDTH-1:0]  MemRdata;

  modport slave (
    input  ReqValid, AluOut, StoreData, Instr, RespReady, MemGnt, MemRvalid, MemRdata,
    output ReqReady, RespValid, LoadData, Misaligned, MemReq, MemWe, MemAddr, MemWdata, MemBe
  );

  modport master (
    output ReqValid, AluOut, StoreData, Instr, RespReady, MemGnt, MemRvalid, MemRdata,
    input  ReqReady, RespValid, LoadData, Misaligned, MemReq, MemWe, MemAddr, MemWdata, MemBe
  );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational store lane steering, load shift/extension, misalignment detect.
// Misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_align
  import Rv32iPkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            i_addr_lo,
  input  logic [2:0]            i_funct3,
  input  logic                  i_is_load,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [3:0]            o_be,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_misaligned
);

  AccSizeT               w_size;
  logic [1:0]            w_off;
  logic [DATA_WIDTH-1:0] w_shifted;

  always_comb begin
    w_size  = acc_size(i_funct3, i_is_load);
    w_off   = '0;
    o_wdata = i_store_data;
    o_be    = '1;
    case (w_size)
      SZ_BYTE: begin
        w_off   = i_addr_lo;
        o_wdata = {(DATA_WIDTH/8){i_store_data[7:0]}};
        o_be    = 4'b0001 << i_addr_lo;
      end
      SZ_HALF: begin
        w_off   = {i_addr_lo[1], 1'b0};
        o_wdata = {(DATA_WIDTH/16){i_store_data[15:0]}};
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
      end
      default: ;
    endcase

    w_shifted   = i_rdata >> {w_off, 3'b000};
    o_load_data = w_shifted;
    case (w_size)
      SZ_BYTE: o_load_data = i_funct3[2] ? {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]}
                                         : {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_load_data = i_funct3[2] ? {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]}
                                         : {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    o_misaligned = ((w_size == SZ_HALF) && i_addr_lo[0]) ||
                   ((w_size == SZ_WORD) && (i_addr_lo != 2'b00));
`else
    o_misaligned = 1'b0;
`endif
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> REQ -> (WAIT) -> RESP handshake FSM.
// Optional misalignment trapping via LSU_MISALIGN_TRAP_EN (see lsu_align).
module load_store_unit
  import Rv32iPkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  load_store_unit_if.slave  bus
);

  LsuStateT              r_state;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_misaligned;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [3:0]            r_mem_be;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic [1:0]            r_addr_lo;
  logic [2:0]            r_funct3;
  logic                  r_is_load;

  logic                  w_idle;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_access;
  logic [1:0]            w_addr_lo;
  logic [2:0]            w_funct3;
  logic                  w_sel_load;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_misaligned;
  logic                  w_unused;

  assign w_idle     = (r_state == IDLE);
  assign w_is_load  = (bus.Instr[6:0] == OP_LOAD);
  assign w_is_store = (bus.Instr[6:0] == OP_STORE);
  assign w_access   = w_is_load | w_is_store;
  assign w_unused   = ^{bus.Instr[INSTR_WIDTH-1:15], bus.Instr[11:7]};

  // One aligner serves both phases: live request fields while IDLE (store
  // steering), registered fields afterwards (load extension in WAIT).
  assign w_addr_lo  = w_idle ? bus.AluOut[1:0]   : r_addr_lo;
  assign w_funct3   = w_idle ? bus.Instr[14:12]  : r_funct3;
  assign w_sel_load = w_idle ? w_is_load         : r_is_load;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_addr_lo    (w_addr_lo),
    .i_funct3     (w_funct3),
    .i_is_load    (w_sel_load),
    .i_store_data (bus.StoreData),
    .i_rdata      (bus.MemRdata),
    .o_wdata      (w_wdata),
    .o_be         (w_be),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_misaligned <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_load_data  <= '0;
      r_addr_lo    <= '0;
      r_funct3     <= '0;
      r_is_load    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.ReqValid) begin
            r_req_ready <= 1'b0;
            r_addr_lo   <= bus.AluOut[1:0];
            r_funct3    <= bus.Instr[14:12];
            r_is_load   <= w_is_load;
            r_load_data <= '0;
            if (w_access && !w_misaligned) begin
              r_state     <= REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_be    <= w_be;
              r_mem_addr  <= {bus.AluOut[DATA_WIDTH-1:2], 2'b00};
              r_mem_wdata <= w_is_store ? w_wdata : '0;
            end else begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_misaligned <= w_access & w_misaligned;
            end
          end
        end
        REQ: begin
          if (bus.MemGnt) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= '0;
            if (r_mem_we) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.MemRvalid) begin
            r_load_data  <= w_load_data;
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.RespReady) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_misaligned <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ReqReady   = r_req_ready;
  assign bus.RespValid  = r_resp_valid;
  assign bus.LoadData   = r_load_data;
  assign bus.Misaligned = r_misaligned;
  assign bus.MemReq     = r_mem_req;
  assign bus.MemWe      = r_mem_we;
  assign bus.MemBe      = r_mem_be;
  assign bus.MemAddr    = r_mem_addr;
  assign bus.MemWdata   = r_mem_wdata;

endmodule
